ft245_device: RTL and testbench

- Device-side (FTDI-chip end) model of the FT245 synchronous FIFO bus. It answers the FPGA host controller by driving `_txe`/`_rxf`, sampling `_rd`/`_wr`/`_oe`, and owning the shared data bus.
- Internal RX FIFO (PC->FPGA) and TX FIFO (FPGA->PC) are fed and drained through ready/valid "PC-side" ports.
- Synthesizable: used for on-chip loopback bring-up and as the bus-functional responder in host-controller benches.

---
 rtl/ft245_pkg.sv | 18 +
 rtl/ft245_sync_fifo.sv | 63 ++++++
 rtl/ft245_device.sv | 146 ++++++++++++++
 tb/tb_ft245_device.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ft245_pkg.sv
// Shared constants and types for the FT245 device-side bus model.
// Build option: FT245_LOOPBACK_EN (see ft245_device.sv).
package ft245_pkg;

  localparam int DEPTH_LOG2_DEFAULT = 4;
  localparam int BUS_W              = 8;

  typedef logic [BUS_W-1:0] bus_t;

  // Value driven onto the bus when the host enables output but the RX FIFO is empty.
  localparam bus_t IDLE_DATA = 8'h00;

  // Number of entries for a given log2 depth.
  function automatic int fifo_depth(input int depth_log2);
    return 1 << depth_log2;
  endfunction

endpackage

// File: rtl/ft245_sync_fifo.sv
// First-word fall-through synchronous FIFO with occupancy and next-occupancy outputs.
// Push on full is refused even when a pop happens in the same cycle (no full bypass).
module ft245_sync_fifo
  import ft245_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic                clk,
  input  logic                _reset,
  input  logic                push,
  input  bus_t                push_data,
  input  logic                pop,
  output bus_t                head,
  output logic [DEPTH_LOG2:0] count,
  output logic [DEPTH_LOG2:0] count_next,
  output logic                full,
  output logic                empty
);

  localparam int                  DEPTH     = fifo_depth(DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  bus_t                  mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Occupancy after this edge; the device uses it to register its bus flags.
  always_comb begin
    count_next = count;
    if (push_ok && !pop_ok) begin
      count_next = count + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_next = count - 1'b1;
    end
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  // Storage write; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ft245_device.sv
// FT245 synchronous FIFO bus, device (FTDI-chip) side.
// Answers a host controller on _txe/_rxf/_rd/_wr/_oe/data and exposes
// ready/valid PC-side ports for the RX (PC->FPGA) and TX (FPGA->PC) FIFOs.
// Build option FT245_LOOPBACK_EN: TX FIFO head is moved into the RX FIFO
// internally and the PC-side ports are idle.
module ft245_device
  import ft245_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic                clk,
  input  logic                _reset,
  output logic                _txe,
  output logic                _rxf,
  input  logic                _rd,
  input  logic                _wr,
  input  logic                _oe,
  inout  wire  [BUS_W-1:0]    data,
  input  logic [BUS_W-1:0]    pc_rx_data,
  input  logic                pc_rx_valid,
  output logic                pc_rx_ready,
  output logic [BUS_W-1:0]    pc_tx_data,
  output logic                pc_tx_valid,
  input  logic                pc_tx_ready,
  output logic [DEPTH_LOG2:0] rx_count,
  output logic [DEPTH_LOG2:0] tx_count,
  output logic                rd_err,
  output logic                wr_err,
  input  logic                err_clr
);

  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(fifo_depth(DEPTH_LOG2));

  logic                oe_q;
  logic                bus_drive;
  bus_t                bus_out;

  bus_t                rx_head;
  bus_t                rx_push_data;
  logic [DEPTH_LOG2:0] rx_count_next;
  logic                rx_full;
  logic                rx_empty;
  logic                rx_push;
  logic                rx_pop;

  bus_t                tx_head;
  logic [DEPTH_LOG2:0] tx_count_next;
  logic                tx_full;
  logic                tx_empty;
  logic                tx_push;
  logic                tx_pop;

  logic                host_rd_bad;
  logic                host_wr_bad;

  // Host side: a read needs output enable to have been low on the previous edge,
  // so the byte has been on the bus for a full cycle before it is consumed.
  assign rx_pop      = !_rd && !_rxf && !oe_q;
  assign host_rd_bad = !_rd && !_rxf && oe_q;
  // A write while the device owns the bus is contention: the byte is dropped.
  assign tx_push     = !_wr && !_txe && _oe;
  assign host_wr_bad = !_wr && !_oe;

`ifdef FT245_LOOPBACK_EN
  logic lb_move;
  logic unused_pc;

  assign lb_move      = !tx_empty && !rx_full;
  assign rx_push      = lb_move;
  assign rx_push_data = tx_head;
  assign tx_pop       = lb_move;
  assign pc_rx_ready  = 1'b0;
  assign pc_tx_valid  = 1'b0;
  assign pc_tx_data   = IDLE_DATA;
  assign unused_pc    = ^{pc_rx_data, pc_rx_valid, pc_tx_ready};
`else
  assign pc_rx_ready  = !rx_full;
  assign rx_push      = pc_rx_valid && pc_rx_ready;
  assign rx_push_data = pc_rx_data;
  assign pc_tx_valid  = !tx_empty;
  assign pc_tx_data   = tx_head;
  assign tx_pop       = pc_tx_valid && pc_tx_ready;
`endif

  logic unused_tx_full;
  assign unused_tx_full = tx_full;

  // Bus drive: RX head (or idle value when empty) whenever the host enables output.
  assign bus_drive = !_oe && _reset;
  assign bus_out   = rx_empty ? IDLE_DATA : rx_head;
  assign data      = bus_drive ? bus_out : {BUS_W{1'bz}};

  ft245_sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_rx_fifo (
    .clk        (clk),
    ._reset     (_reset),
    .push       (rx_push),
    .push_data  (rx_push_data),
    .pop        (rx_pop),
    .head       (rx_head),
    .count      (rx_count),
    .count_next (rx_count_next),
    .full       (rx_full),
    .empty      (rx_empty)
  );

  ft245_sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_tx_fifo (
    .clk        (clk),
    ._reset     (_reset),
    .push       (tx_push),
    .push_data  (data),
    .pop        (tx_pop),
    .head       (tx_head),
    .count      (tx_count),
    .count_next (tx_count_next),
    .full       (tx_full),
    .empty      (tx_empty)
  );

  // Previous-edge output enable; sampled even in reset since it only reflects the host.
  always_ff @(posedge clk) begin
    oe_q <= _oe;
  end

  // Bus flags from next occupancy, so the emptying pop raises _rxf on its own edge;
  // sticky errors where a same-cycle set wins over err_clr.
  always_ff @(posedge clk) begin
    if (!_reset) begin
      _rxf   <= 1'b1;
      _txe   <= 1'b1;
      rd_err <= 1'b0;
      wr_err <= 1'b0;
    end else begin
      _rxf <= (rx_count_next == '0);
      _txe <= (tx_count_next == DEPTH_CNT);
      if (host_rd_bad)  rd_err <= 1'b1;
      else if (err_clr) rd_err <= 1'b0;
      if (host_wr_bad)  wr_err <= 1'b1;
      else if (err_clr) wr_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ft245_device.sv
// Bench for ft245_device: directed scenarios plus randomized host/PC traffic
// compared every cycle against a queue-based model of the two FIFOs.
module tb_ft245_device;

  localparam int DL2   = 4;
  localparam int DEPTH = 1 << DL2;

  logic           clk = 1'b0;
  logic           _reset, _rd, _wr, _oe, err_clr;
  logic           pc_rx_valid, pc_tx_ready;
  logic [7:0]     pc_rx_data, host_data;
  wire  [7:0]     data;
  logic           _txe, _rxf, pc_rx_ready, pc_tx_valid, rd_err, wr_err;
  logic [7:0]     pc_tx_data;
  logic [DL2:0]   rx_count, tx_count;

  always #5 clk = ~clk;

  // Host drives the bus only while it holds output enable high.
  assign data = _oe ? host_data : 8'bz;

  ft245_device #(.DEPTH_LOG2(DL2)) dut (
    .clk         (clk),
    ._reset      (_reset),
    ._txe        (_txe),
    ._rxf        (_rxf),
    ._rd         (_rd),
    ._wr         (_wr),
    ._oe         (_oe),
    .data        (data),
    .pc_rx_data  (pc_rx_data),
    .pc_rx_valid (pc_rx_valid),
    .pc_rx_ready (pc_rx_ready),
    .pc_tx_data  (pc_tx_data),
    .pc_tx_valid (pc_tx_valid),
    .pc_tx_ready (pc_tx_ready),
    .rx_count    (rx_count),
    .tx_count    (tx_count),
    .rd_err      (rd_err),
    .wr_err      (wr_err),
    .err_clr     (err_clr)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Model state
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  bit m_rxf, m_txe, m_oeq, m_rderr, m_wrerr;
  bit live      = 0;
  bit use_model = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic compare_model();
    bit drv;
    drv = !_oe && _reset;
    chk("rxf", _rxf, m_rxf);
    chk("txe", _txe, m_txe);
    chk("rx_count", rx_count, rx_q.size());
    chk("tx_count", tx_count, tx_q.size());
    chk("pc_rx_ready", pc_rx_ready, rx_q.size() < DEPTH);
    chk("pc_tx_valid", pc_tx_valid, tx_q.size() != 0);
    if (tx_q.size() != 0) chk("pc_tx_data", pc_tx_data, tx_q[0]);
    chk("rd_err", rd_err, m_rderr);
    chk("wr_err", wr_err, m_wrerr);
    chk("bus_drive", dut.bus_drive, drv);
    if (drv) chk("data", data, (rx_q.size() != 0) ? rx_q[0] : 8'h00);
  endtask

  task automatic model_step();
    bit rd_pop, rd_e, wr_push, wr_e, rx_in, tx_out;
    logic [7:0] tmp;
    if (!_reset) begin
      rx_q.delete();
      tx_q.delete();
      m_rxf = 1; m_txe = 1; m_rderr = 0; m_wrerr = 0;
      live = 1;
    end else if (live) begin
      rd_pop  = !_rd && !m_rxf && !m_oeq;
      rd_e    = !_rd && !m_rxf && m_oeq;
      wr_push = !_wr && !m_txe && _oe;
      wr_e    = !_wr && !_oe;
      rx_in   = pc_rx_valid && (rx_q.size() < DEPTH);
      tx_out  = pc_tx_ready && (tx_q.size() > 0);
      if (rd_pop)  tmp = rx_q.pop_front();
      if (rx_in)   rx_q.push_back(pc_rx_data);
      if (tx_out)  tmp = tx_q.pop_front();
      if (wr_push) tx_q.push_back(host_data);
      m_rxf = (rx_q.size() == 0);
      m_txe = (tx_q.size() == DEPTH);
      if (rd_e) m_rderr = 1; else if (err_clr) m_rderr = 0;
      if (wr_e) m_wrerr = 1; else if (err_clr) m_wrerr = 0;
    end
    m_oeq = _oe;
  endtask

  // One bus cycle: compare at the falling edge, advance the model, return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (live && use_model) compare_model();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    _rd = 1; _wr = 1; _oe = 1; err_clr = 0;
    pc_rx_valid = 0; pc_tx_ready = 0;
  endtask

  initial begin
    bit seen;
    _reset = 0; idle_inputs(); _oe = 0;
    host_data = 8'h00; pc_rx_data = 8'h00;
    @(posedge clk); #1;
    tick();
    #1;
    chk("reset rxf", _rxf, 1);
    chk("reset txe", _txe, 1);
    chk("reset rx_count", rx_count, 0);
    chk("reset rd_err", rd_err, 0);
    chk("reset bus z", dut.bus_drive, 0);

    _reset = 1; _oe = 1;
    tick();
    chk("txe low after release", _txe, 0);

`ifdef FT245_LOOPBACK_EN
    use_model = 0;
    _wr = 0; host_data = 8'h3C;
    tick();
    _wr = 1;
    seen = 0;
    for (int i = 0; i < 3 && !seen; i++) begin
      tick();
      if (_rxf == 1'b0) seen = 1;
    end
    chk("loopback rxf within 3", seen, 1);
    _oe = 0; #1;
    chk("loopback data", data, 8'h3C);
    tick();
    _rd = 0;
    tick();
    _rd = 1; #1;
    chk("loopback rxf after pop", _rxf, 1);
    _oe = 1;
`else
    // PC push of A5, then host read with output enable held from the prior cycle.
    pc_rx_valid = 1; pc_rx_data = 8'hA5;
    tick();
    pc_rx_valid = 0; _oe = 0; #1;
    chk("rxf low after push", _rxf, 0);
    chk("rx_count after push", rx_count, 1);
    chk("data A5 under oe", data, 8'hA5);
    tick();
    _rd = 0;
    tick();
    _rd = 1; #1;
    chk("rxf high after pop", _rxf, 1);
    chk("rx_count after pop", rx_count, 0);
    chk("idle data", data, 8'h00);
    _oe = 1;

    // Fill TX FIFO from the host, overflow write, then drain on the PC side.
    _wr = 0;
    for (int i = 0; i < DEPTH; i++) begin
      host_data = 8'(i);
      tick();
    end
    chk("txe high when full", _txe, 1);
    chk("tx_count full", tx_count, DEPTH);
    host_data = 8'hFF;
    tick();
    _wr = 1; #1;
    chk("overflow dropped", tx_count, DEPTH);
    pc_tx_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain order", pc_tx_data, 8'(i));
      tick();
    end
    pc_tx_ready = 0; #1;
    chk("tx drained", tx_count, 0);

    // Read strobe together with output enable (not before) is an error, not a pop.
    pc_rx_valid = 1; pc_rx_data = 8'h5A;
    tick();
    pc_rx_valid = 0;
    tick();
    _rd = 0; _oe = 0;
    tick();
    _rd = 1; #1;
    chk("rd_err set", rd_err, 1);
    chk("no pop on rd_err", rx_count, 1);
    err_clr = 1;
    tick();
    err_clr = 0; #1;
    chk("rd_err cleared", rd_err, 0);
    _oe = 1;

    // Write while the device owns the bus.
    _wr = 0; _oe = 0;
    tick();
    _wr = 1; #1;
    chk("wr_err set", wr_err, 1);
    chk("contended write dropped", tx_count, 0);
    err_clr = 1; _oe = 1;
    tick();
    err_clr = 0;

    // Reset in the middle of a read burst with five bytes queued.
    pc_rx_valid = 1;
    for (int i = 0; i < 4; i++) begin
      pc_rx_data = 8'($urandom);
      tick();
    end
    pc_rx_valid = 0; _oe = 0;
    tick();
    chk("rx_count five", rx_count, 5);
    _rd = 0;
    tick();
    _reset = 0;
    tick();
    #1;
    chk("reset mid-burst rxf", _rxf, 1);
    chk("reset mid-burst rx_count", rx_count, 0);
    chk("reset mid-burst bus z", dut.bus_drive, 0);
    _reset = 1; idle_inputs();
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      _reset      = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 4) == 0) _oe = ~_oe;
      _rd         = ($urandom_range(0, 9) < 5);
      _wr         = ($urandom_range(0, 9) < 5);
      err_clr     = ($urandom_range(0, 19) == 0);
      pc_rx_valid = $urandom_range(0, 1);
      pc_tx_ready = ($urandom_range(0, 9) < 4);
      pc_rx_data  = 8'($urandom);
      host_data   = 8'($urandom);
      tick();
    end
    _reset = 1; idle_inputs();
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
